memory_port: RTL and testbench
==============================

MEMORY_PORT -- requirements
Module: memory_port

Interface
REQ-001 Parameter AddrWidth, default 10, word-address width; depth = 2**AddrWidth words.
REQ-002 Parameter DataWidth, default 32, data word width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high; sampled on the rising edge of clk.
REQ-005 addr  input  AddrWidth+1  bit [AddrWidth] = request valid; bits [AddrWidth-1:0] = word address (upstream address-mux format).
REQ-006 wdat  input  DataWidth+1  bit [DataWidth] = write enable; bits [DataWidth-1:0] = write data (upstream write-data-mux format).
REQ-007 req_ready  output  1  high when a request presented this cycle is accepted.
REQ-008 rdata  output  DataWidth  read data at the head of the output queue.
REQ-009 rvalid  output  1  rdata is valid.
REQ-010 rready  input  1  consumer takes rdata when rvalid and rready are both high.
REQ-011 err  output  1  sticky protocol-error flag.

Function
REQ-012 Request accepted on an edge where addr[AddrWidth]=1 and req_ready=1; otherwise no storage or queue state changes from that request.
REQ-013 Accepted request with wdat[DataWidth]=1 is a write: mem[addr] <= wdat data on that edge; no read data is produced.
REQ-014 Accepted request with wdat[DataWidth]=0 is a read; it enters a 2-stage read pipeline (RAM register, output register).
REQ-015 Read accepted on edge E0 enters the output queue on edge E2; with an empty queue, rvalid=1 and rdata valid in the cycle after E2 (latency 2 cycles).
REQ-016 Read of an address written on an earlier edge returns the new data, including a write on E0 followed by a read on E1 (write-then-read, no stale data).
REQ-017 Output queue: 4-entry FIFO, first-word-fall-through; rdata/rvalid reflect the head entry; head pops on an edge where rvalid and rready are both high.
REQ-018 Reads return strictly in acceptance order.
REQ-019 Credit rule: req_ready = (queue occupancy + reads in the pipeline) < 4, evaluated combinationally from registered state; req_ready is independent of the current request's type and of rready.
REQ-020 Simultaneous push (pipeline exit) and pop on the same edge: occupancy unchanged, order preserved; allowed when the queue is full.
REQ-021 With rready held low, no more than 4 reads are outstanding; queue never overflows; rdata stays stable while rvalid=1 and rready=0.
REQ-022 Write requests are accepted while req_ready=1 even if the queue is full of read data... no: writes follow the same req_ready gating as reads (REQ-019).
REQ-023 err set on any edge where wdat[DataWidth]=1 and addr[AddrWidth]=0 (orphan write data); the orphan data is ignored; err clears only on reset.
REQ-024 Address wrap: all AddrWidth bits are used directly; no out-of-range condition exists.

Reset
REQ-025 rst=1 on an edge: queue emptied, pipeline valids cleared, err=0; after that edge rvalid=0, req_ready=1.
REQ-026 Reset during operation discards all in-flight and queued reads; no rvalid pulse from them appears after reset.
REQ-027 Memory contents are not reset; requests presented while rst=1 are ignored (no write occurs).

Verification
REQ-028 Write 0xDEADBEEF to addr 5, next cycle read addr 5, rready=1 -> rvalid=1 two cycles after read accept, rdata=0xDEADBEEF.
REQ-029 rready=0, reads to addr 0..5 presented back-to-back -> exactly 4 accepted, req_ready=0 thereafter; raise rready -> data for addr 0,1,2,3 in order, then req_ready returns to 1.
REQ-030 Queue full with rready=1 and new reads every cycle -> sustained one pop and one push per edge, no loss, no duplication.
REQ-031 wdat valid=1 with addr valid=0 -> err=1 and stays 1; memory unchanged; err=0 after rst.
REQ-032 Reset asserted one cycle after 2 reads accepted -> no rvalid after reset; req_ready=1 on the first post-reset cycle; previously written data still readable.
REQ-033 Writes to addr 0 and addr 2**AddrWidth-1 then reads -> each returns its own data, no aliasing.

Source files
------------

// File: rtl/memory_port.sv
// memory_port: single-port word RAM with 2-stage read pipeline, credit-gated 4-entry FWFT read queue and sticky error flag.
module memory_port #(
  parameter int AddrWidth = 10,
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AddrWidth:0]   addr,
  input  logic [DataWidth:0]   wdat,
  output logic                 req_ready,
  output logic [DataWidth-1:0] rdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 err
);
  logic [DataWidth-1:0] mem [2**AddrWidth];
  logic [DataWidth-1:0] q [4];
  logic [DataWidth-1:0] s1_data, s2_data;
  logic                 s1_valid, s2_valid;
  logic [1:0]           wp, rp;
  logic [2:0]           cnt;
  logic                 acc, wr, rd, push, pop;
  // credits cover queued entries plus reads still in the pipeline, so a push never meets a full queue without a pop
  assign req_ready = (cnt + {2'b0, s1_valid} + {2'b0, s2_valid}) < 3'd4;
  assign acc       = addr[AddrWidth] & req_ready & ~rst;
  assign wr        = acc & wdat[DataWidth];
  assign rd        = acc & ~wdat[DataWidth];
  assign push      = s2_valid;
  assign rvalid    = cnt != 3'd0;
  assign pop       = rvalid & rready;
  assign rdata     = q[rp];
  always_ff @(posedge clk) begin
    if (wr) mem[addr[AddrWidth-1:0]] <= wdat[DataWidth-1:0];
    if (rd) s1_data <= mem[addr[AddrWidth-1:0]];
    s2_data <= s1_data;
    if (push) q[wp] <= s2_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      wp       <= 2'd0;
      rp       <= 2'd0;
      cnt      <= 3'd0;
      err      <= 1'b0;
    end else begin
      s1_valid <= rd;
      s2_valid <= s1_valid;
      wp       <= wp + {1'b0, push};
      rp       <= rp + {1'b0, pop};
      cnt      <= cnt + {2'b0, push} - {2'b0, pop};
      err      <= err | (wdat[DataWidth] & ~addr[AddrWidth]);
    end
  end
endmodule

// File: tb/tb_memory_port.sv
// tb_memory_port: scoreboard bench for memory_port; a reference memory predicts read data in acceptance order.
module tb_memory_port;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] addr;
  logic [32:0] wdat;
  logic        req_ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        err;
  logic [31:0] mdl [1024];
  logic [31:0] sb [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          base;
  int          seen;
  memory_port dut (
    .clk(clk), .rst(rst), .addr(addr), .wdat(wdat), .req_ready(req_ready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic req(input logic v, input logic [9:0] a, input logic we, input logic [31:0] d);
    addr = {v, a};
    wdat = {we, d};
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) req(1'b0, 10'd0, 1'b0, 32'd0);
  endtask
  task automatic drain();
    rready = 1'b1;
    for (int i = 0; i < 60 && sb.size() > 0; i++) idle(1);
    idle(4);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask
  // inputs are stable at the falling edge, so the handshakes of the coming rising edge are known here
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (rvalid && rready) begin
        if (sb.size() == 0) check("rvalid_unexpected", 64'd1, 64'd0);
        else check("rdata", 64'(rdata), 64'(sb.pop_front()));
      end
      if (addr[10] && req_ready) begin
        acc_cnt++;
        if (wdat[32]) mdl[addr[9:0]] = wdat[31:0];
        else sb.push_back(mdl[addr[9:0]]);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    rready = 1'b0;
    addr = '0;
    wdat = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) req(1'b1, 10'(i), 1'b1, $urandom);
    rready = 1'b1;
    req(1'b1, 10'd5, 1'b1, 32'hDEADBEEF);
    req(1'b1, 10'd5, 1'b0, 32'd0);
    idle(1);
    check("lat_e1_rvalid", 64'(rvalid), 64'd0);
    idle(1);
    check("lat_e2_rvalid", 64'(rvalid), 64'd1);
    check("lat_e2_rdata", 64'(rdata), 64'hDEADBEEF);
    drain();
    for (int i = 0; i < 6; i++) req(1'b1, 10'(i), 1'b1, 32'h1000_0000 + 32'(i));
    rready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 6; i++) req(1'b1, 10'(i), 1'b0, 32'd0);
    check("credit_accepts", 64'(acc_cnt - base), 64'd4);
    check("credit_ready_low", 64'(req_ready), 64'd0);
    idle(3);
    check("hold_rvalid", 64'(rvalid), 64'd1);
    check("hold_rdata", 64'(rdata), 64'h1000_0000);
    check("hold_ready_low", 64'(req_ready), 64'd0);
    drain();
    check("credit_ready_back", 64'(req_ready), 64'd1);
    rready = 1'b0;
    for (int i = 8; i < 12; i++) req(1'b1, 10'(i), 1'b0, 32'd0);
    idle(2);
    rready = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 30; i++) req(1'b1, 10'($urandom_range(0, 15)), 1'b0, 32'd0);
    check("stream_accepts_min", 64'(acc_cnt - base >= 20), 64'd1);
    drain();
    req(1'b0, 10'd7, 1'b1, 32'hBAD0BAD0);
    check("orphan_err", 64'(err), 64'd1);
    idle(3);
    check("orphan_err_sticky", 64'(err), 64'd1);
    req(1'b1, 10'd7, 1'b0, 32'd0);
    drain();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("orphan_err_cleared", 64'(err), 64'd0);
    req(1'b1, 10'd5, 1'b0, 32'd0);
    req(1'b1, 10'd6, 1'b0, 32'd0);
    rst = 1'b1;
    req(1'b1, 10'd5, 1'b1, 32'h12345678);
    rst = 1'b0;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_rvalid", 64'(rvalid), 64'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (rvalid) seen++;
    end
    check("post_rst_no_rvalid", 64'(seen), 64'd0);
    req(1'b1, 10'd5, 1'b0, 32'd0);
    drain();
    req(1'b1, 10'd0, 1'b1, 32'hA5A5_0000);
    req(1'b1, 10'd1023, 1'b1, 32'h5A5A_03FF);
    req(1'b1, 10'd0, 1'b0, 32'd0);
    req(1'b1, 10'd1023, 1'b0, 32'd0);
    drain();
    for (int i = 0; i < 300; i++) begin
      rready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: idle(1);
        1: req(1'b1, 10'($urandom_range(0, 15)), 1'b1, $urandom);
        default: req(1'b1, 10'($urandom_range(0, 15)), 1'b0, 32'd0);
      endcase
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
